// File: rtl/wave_sequencer.sv
// wave_sequencer: debounces frequency-change requests, launches them to the
// wave computation block with a new_f pulse, waits for the fill to finish,
// and arbitrates that block's single read port between display (rd0) and
// surfer physics (rd1).
module wave_sequencer #(
  parameter int MIN_HOLD = 16,   // cycles a request must stay pending before launch (>=1)
  parameter int TIMEOUT  = 2100  // max cycles waiting for wave_ready
) (
  input  logic        clock,
  input  logic        reset,
  // frequency request channel
  input  logic        req_valid,
  input  logic [4:0]  req_freq_id,
  output logic        req_ready,
  // wave computation block control
  output logic [4:0]  freq_id,
  output logic        new_f,
  input  logic        wave_ready,
  // status
  output logic        busy,
  output logic [4:0]  cur_freq_id,
  output logic        done,
  output logic        timeout_err,
  // display read port (absolute priority)
  input  logic        rd0_req,
  input  logic [10:0] rd0_index,
  output logic        rd0_valid,
  // physics read port
  input  logic        rd1_req,
  input  logic [10:0] rd1_index,
  output logic        rd1_grant,
  output logic        rd1_valid,
  // shared read port towards the wave computation block
  output logic [10:0] wave_index,
  input  logic [9:0]  wave_height_in,
  output logic [9:0]  rd_data
);

  localparam logic [4:0] MAX_FREQ_ID = 5'd24;
  localparam int         HOLD_W      = $clog2(MIN_HOLD + 1);
  localparam int         TO_W        = $clog2(TIMEOUT + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MIN_HOLD - 1);
  localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_HOLD,
    S_LAUNCH,
    S_WAIT
  } state_t;

  state_t            state, state_next;
  logic [4:0]        pending, pending_next;
  logic [HOLD_W-1:0] hold_cnt, hold_cnt_next;
  logic [TO_W-1:0]   to_cnt, to_cnt_next;
  logic              launch, commit, expire;
  logic              accept;
  logic [4:0]        req_id;
  logic [10:0]       last_index;

  // Out-of-range requests are clamped to the highest valid frequency.
  assign req_id    = (req_freq_id > MAX_FREQ_ID) ? MAX_FREQ_ID : req_freq_id;
  assign req_ready = (state == S_IDLE) || (state == S_HOLD);
  assign accept    = req_valid && req_ready;
  assign busy      = (state == S_LAUNCH) || (state == S_WAIT);

  // Next-state logic: debounce, launch, wait-for-fill with timeout.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    state_next    = state;
    pending_next  = pending;
    hold_cnt_next = '0;
    to_cnt_next   = '0;
    launch        = 1'b0;
    commit        = 1'b0;
    expire        = 1'b0;
    unique case (state)
      S_IDLE: begin
        // A request for the frequency already on screen is a no-op.
        if (accept && req_id != cur_freq_id) begin
          pending_next = req_id;
          state_next   = S_HOLD;
        end
      end
      S_HOLD: begin
        hold_cnt_next = hold_cnt + 1'b1;
        if (accept && req_id == cur_freq_id) begin
          state_next = S_IDLE;
        end else if (accept && req_id != pending) begin
          // A new target restarts the stability window.
          pending_next  = req_id;
          hold_cnt_next = '0;
        end else if (hold_cnt == HOLD_LAST) begin
          state_next = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        launch     = 1'b1;
        state_next = S_WAIT;
      end
      S_WAIT: begin
        to_cnt_next = to_cnt + 1'b1;
        // wave_ready takes precedence over a timeout in the same cycle.
        if (wave_ready) begin
          commit     = 1'b1;
          state_next = S_IDLE;
        end else if (to_cnt == TO_LAST) begin
          expire     = 1'b1;
          state_next = S_IDLE;
        end
      end
      default: state_next = S_WAIT;
    endcase
  end

  // Control state and registered outputs; freq_id only moves on launch so the
  // downstream ROM sees a stable value for the whole fill.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state       <= S_WAIT;
      pending     <= '0;
      hold_cnt    <= '0;
      to_cnt      <= '0;
      freq_id     <= '0;
      cur_freq_id <= '0;
      new_f       <= 1'b0;
      done        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state    <= state_next;
      pending  <= pending_next;
      hold_cnt <= hold_cnt_next;
      to_cnt   <= to_cnt_next;
      new_f    <= launch;
      done     <= commit;
      if (launch) freq_id     <= pending;
      if (commit) cur_freq_id <= pending;
      if (expire) timeout_err <= 1'b1;
    end
  end

  // Read-port arbitration: rd0 always wins; rd1 only while the wave is stable.
  always_comb begin
    rd1_grant  = rd1_req && !rd0_req && (state != S_WAIT) && (state != S_LAUNCH);
    wave_index = last_index;
    if (rd0_req)        wave_index = rd0_index;
    else if (rd1_grant) wave_index = rd1_index;
  end

  // Read data capture and per-requester valid flags, one cycle after the index.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_index <= '0;
      rd0_valid  <= 1'b0;
      rd1_valid  <= 1'b0;
      rd_data    <= '0;
    end else begin
      last_index <= wave_index;
      rd0_valid  <= rd0_req;
      rd1_valid  <= rd1_grant;
      rd_data    <= wave_height_in;
    end
  end

endmodule

// File: tb/tb_wave_sequencer.sv
// tb_wave_sequencer: directed scenarios plus randomized traffic, checked every
// cycle against a deadline-based reference model of the sequencer.
module tb_wave_sequencer;

  localparam int MIN_HOLD = 16;
  localparam int TIMEOUT  = 2100;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic [4:0]  req_freq_id = '0;
  logic        req_ready;
  logic [4:0]  freq_id;
  logic        new_f;
  logic        wave_ready = 1'b0;
  logic        busy;
  logic [4:0]  cur_freq_id;
  logic        done;
  logic        timeout_err;
  logic        rd0_req = 1'b0;
  logic [10:0] rd0_index = '0;
  logic        rd0_valid;
  logic        rd1_req = 1'b0;
  logic [10:0] rd1_index = '0;
  logic        rd1_grant;
  logic        rd1_valid;
  logic [10:0] wave_index;
  logic [9:0]  wave_height_in;
  logic [9:0]  rd_data;

  logic [9:0]  height [2048];

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: requests become launch deadlines, waits become timeout
  // deadlines, all measured in absolute clock-edge numbers.
  int m_edge = 0;
  bit m_known = 0;
  bit m_wait, m_launch, m_new_f, m_done, m_terr;
  bit m_rd0_valid, m_rd1_valid;
  int m_cur, m_freq, m_pending, m_hold_end, m_launch_id, m_deadline, m_last_idx;
  int m_rd_data;

  always #5 clock = ~clock;

  // Downstream block modelled as a combinational lookup of the index.
  assign wave_height_in = height[wave_index];

  wave_sequencer #(.MIN_HOLD(MIN_HOLD), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_freq_id(req_freq_id), .req_ready(req_ready),
    .freq_id(freq_id), .new_f(new_f), .wave_ready(wave_ready),
    .busy(busy), .cur_freq_id(cur_freq_id), .done(done), .timeout_err(timeout_err),
    .rd0_req(rd0_req), .rd0_index(rd0_index), .rd0_valid(rd0_valid),
    .rd1_req(rd1_req), .rd1_index(rd1_index), .rd1_grant(rd1_grant), .rd1_valid(rd1_valid),
    .wave_index(wave_index), .wave_height_in(wave_height_in), .rd_data(rd_data)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check combinational outputs mid-cycle, advance the model
  // on the edge, then check registered outputs just after it.
  task automatic step();
    int  idx, id;
    bit  idle, grant;
    @(negedge clock);
    idle  = !m_wait && !m_launch;
    grant = rd1_req && !rd0_req && idle;
    idx   = rd0_req ? int'(rd0_index) : (grant ? int'(rd1_index) : m_last_idx);
    if (!reset && m_known) begin
      check("req_ready", req_ready, idle);
      check("busy", busy, !idle);
      check("rd1_grant", rd1_grant, grant);
      check("wave_index", wave_index, idx);
    end
    m_edge++;
    m_new_f = 0;
    m_done  = 0;
    if (reset) begin
      m_known = 1; m_wait = 1; m_launch = 0; m_launch_id = 0; m_pending = -1;
      m_cur = 0; m_freq = 0; m_terr = 0; m_deadline = m_edge + TIMEOUT;
      m_rd0_valid = 0; m_rd1_valid = 0; m_rd_data = 0; m_last_idx = 0;
    end else begin
      m_rd0_valid = rd0_req;
      m_rd1_valid = grant;
      m_rd_data   = height[idx];
      m_last_idx  = idx;
      if (m_wait) begin
        if (wave_ready) begin
          m_cur = m_launch_id; m_done = 1; m_wait = 0;
        end else if (m_edge == m_deadline) begin
          m_terr = 1; m_wait = 0;
        end
      end else if (m_launch) begin
        m_launch = 0; m_new_f = 1; m_freq = m_launch_id;
        m_wait = 1; m_deadline = m_edge + TIMEOUT;
      end else begin
        if (req_valid) begin
          id = (req_freq_id > 5'd24) ? 24 : int'(req_freq_id);
          if (id == m_cur) m_pending = -1;
          else if (id != m_pending) begin
            m_pending = id; m_hold_end = m_edge + MIN_HOLD;
          end
        end
        if (m_pending >= 0 && m_edge == m_hold_end) begin
          m_launch = 1; m_launch_id = m_pending; m_pending = -1;
        end
      end
    end
    @(posedge clock);
    #1;
    check("new_f", new_f, m_new_f);
    check("done", done, m_done);
    check("freq_id", freq_id, m_freq);
    check("cur_freq_id", cur_freq_id, m_cur);
    check("timeout_err", timeout_err, m_terr);
    check("rd0_valid", rd0_valid, m_rd0_valid);
    check("rd1_valid", rd1_valid, m_rd1_valid);
    check("rd_data", rd_data, m_rd_data);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic request(input logic [4:0] id);
    req_valid = 1'b1; req_freq_id = id;
    step();
    req_valid = 1'b0;
  endtask

  // Steps until new_f is seen; returns the number of steps taken (limit+1 on expiry).
  task automatic wait_new_f(input int limit, output int k);
    k = 0;
    do begin step(); k++; end while (!new_f && k <= limit);
  endtask

  task automatic commit_fill();
    wave_ready = 1'b1; step(); wave_ready = 1'b0;
  endtask

  initial begin
    int k, pulses;
    for (int i = 0; i < 2048; i++) height[i] = 10'($urandom);

    // Reset and initial self-fill commit of frequency 0
    steps(2);
    reset = 1'b0;
    check("reset_busy", busy, 1'b1);
    steps(1029);
    commit_fill();
    check("boot_done", done, 1'b1);
    check("boot_cur", cur_freq_id, 5'd0);
    check("boot_terr", timeout_err, 1'b0);
    step();
    check("boot_idle", req_ready, 1'b1);

    // Retarget then cancel back to the current frequency: nothing launches
    request(5'd7);
    steps(9);
    request(5'd9);
    steps(4);
    request(5'd0);
    pulses = 0;
    for (int i = 0; i < 40; i++) begin step(); pulses += int'(new_f); end
    check("cancel_no_launch", pulses, 0);
    check("cancel_idle", req_ready, 1'b1);
    check("cancel_cur", cur_freq_id, 5'd0);

    // Single request: launch latency, then commit
    request(5'd7);
    wait_new_f(40, k);
    check("launch_latency", k, 17);
    check("launch_freq", freq_id, 5'd7);
    steps(599);
    commit_fill();
    check("commit7_done", done, 1'b1);
    check("commit7_cur", cur_freq_id, 5'd7);
    step();
    check("done_one_cycle", done, 1'b0);

    // Clamp of an out-of-range id; requests during WAIT are refused
    request(5'd30);
    wait_new_f(40, k);
    check("clamp_freq", freq_id, 5'd24);
    req_valid = 1'b1; req_freq_id = 5'd3;
    #1;
    check("wait_req_ready", req_ready, 1'b0);
    steps(3);
    req_valid = 1'b0;
    commit_fill();
    check("clamp_cur", cur_freq_id, 5'd24);
    pulses = 0;
    for (int i = 0; i < 30; i++) begin step(); pulses += int'(new_f); end
    check("wait_req_dropped", pulses, 0);

    // Timeout: sticky error, committed frequency unchanged, cleared by reset
    request(5'd5);
    wait_new_f(40, k);
    k = 0;
    do begin step(); k++; end while (!timeout_err && k <= TIMEOUT + 50);
    check("timeout_latency", k, TIMEOUT);
    check("timeout_cur", cur_freq_id, 5'd24);
    steps(5);
    check("timeout_sticky", timeout_err, 1'b1);
    check("timeout_idle", req_ready, 1'b1);
    reset = 1'b1; step(); reset = 1'b0;
    check("reset_clears_terr", timeout_err, 1'b0);
    steps(10);
    commit_fill();

    // Read arbitration
    rd0_req = 1'b1; rd0_index = 11'd5; rd1_req = 1'b1; rd1_index = 11'd9;
    #1;
    check("arb_index_rd0", wave_index, 11'd5);
    check("arb_no_grant", rd1_grant, 1'b0);
    step();
    check("arb_rd0_valid", rd0_valid, 1'b1);
    check("arb_rd0_data", rd_data, height[5]);
    rd0_req = 1'b0;
    #1;
    check("arb_grant", rd1_grant, 1'b1);
    check("arb_index_rd1", wave_index, 11'd9);
    step();
    check("arb_rd1_valid", rd1_valid, 1'b1);
    check("arb_rd1_data", rd_data, height[9]);
    rd1_req = 1'b0;
    #1;
    check("arb_index_hold", wave_index, 11'd9);
    request(5'd11);
    wait_new_f(40, k);
    rd1_req = 1'b1;
    #1;
    check("arb_wait_no_grant", rd1_grant, 1'b0);
    step();
    check("arb_wait_no_valid", rd1_valid, 1'b0);
    rd1_req = 1'b0;
    commit_fill();

    // Randomized traffic with one mid-run reset
    for (int i = 0; i < 3000; i++) begin
      req_valid   = ($urandom_range(0, 7) == 0);
      req_freq_id = 5'($urandom_range(0, 31));
      wave_ready  = ($urandom_range(0, 39) == 0);
      rd0_req     = ($urandom_range(0, 2) == 0);
      rd0_index   = 11'($urandom);
      rd1_req     = ($urandom_range(0, 1) == 0);
      rd1_index   = 11'($urandom);
      reset       = (i == 1500);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/wave_sequencer.md
Name: wave_sequencer

Overview:
- Controller between the pitch/frequency front end and the wave computation block.
- Accepts frequency-change requests over a valid/ready handshake and debounces them with a stability hold.
- Issues the one-cycle new_f pulse with a stable freq_id, waits for wave_ready, and tracks the committed frequency.
- Arbitrates the wave computation block's single index/wave_height read port between the display renderer (rd0) and surfer physics (rd1).

Parameters:
MIN_HOLD, 16, cycles a requested freq_id must stay pending before it is launched (>=1)
TIMEOUT, 2100, max cycles in WAIT for wave_ready before abort (covers 1024-entry fill plus margin)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
req_valid  in  1  frequency request valid
req_freq_id  in  5  requested freq id, 0..24
req_ready  out  1  request accepted when req_valid&req_ready
freq_id  out  5  to wave computation block freq_id
new_f  out  1  to wave computation block, one-cycle pulse
wave_ready  in  1  from wave computation block, fill complete pulse
busy  out  1  high in LAUNCH or WAIT
cur_freq_id  out  5  last committed frequency id
done  out  1  one-cycle pulse on commit
timeout_err  out  1  sticky; set on WAIT timeout, cleared only by reset
rd0_req  in  1  display read request
rd0_index  in  11  display read index
rd0_valid  out  1  rd_data holds rd0's result this cycle
rd1_req  in  1  physics read request
rd1_index  in  11  physics read index
rd1_grant  out  1  rd1 request taken this cycle
rd1_valid  out  1  rd_data holds rd1's result this cycle
wave_index  out  11  to wave computation block index
wave_height_in  in  10  from wave computation block wave_height
rd_data  out  10  read data, registered copy of wave_height_in

Behaviour:
- Reset values:
  - state=WAIT, pending=0, freq_id=0, cur_freq_id=0.
  - new_f=0, done=0, timeout_err=0, hold/timeout counters=0.
  - rd0_valid=0, rd1_valid=0, rd1_grant=0, rd_data=0.
- The wave computation block self-fills on reset, so WAIT is entered immediately and commits freq 0 on the first wave_ready.
- Request sanitising: req_freq_id>24 is clamped to 24 on acceptance.
- States:
  - IDLE, req_ready=1:
    - Accepted request equal to cur_freq_id is dropped.
    - Otherwise pending<=id, hold_cnt<=0, go to HOLD.
  - HOLD, req_ready=1, hold_cnt increments each cycle:
    - Accepted id equal to cur_freq_id cancels and returns to IDLE.
    - Accepted id different from pending sets pending<=id and hold_cnt<=0.
    - Accepted id equal to pending has no effect.
    - hold_cnt==MIN_HOLD-1 with no accepted differing request: go to LAUNCH.
  - LAUNCH, req_ready=0: freq_id<=pending and new_f=1 for exactly one cycle; to_cnt<=0; go to WAIT.
  - WAIT, req_ready=0, freq_id held constant:
    - wave_ready: cur_freq_id<=pending, done=1 for one cycle, go to IDLE.
    - Else to_cnt==TIMEOUT-1: timeout_err<=1, cur_freq_id unchanged, go to IDLE.
    - wave_ready and timeout in the same cycle: wave_ready wins.
- freq_id changes only in LAUNCH, since the downstream ROM samples it combinationally during the first fill cycle.
- Read arbitration: the downstream read is registered, so index in cycle N gives data in cycle N+1.
  - rd0 has absolute priority and is never stalled: rd0_req => wave_index=rd0_index, rd0_valid=1 next cycle.
  - rd1_grant=rd1_req & !rd0_req & state!=WAIT & state!=LAUNCH (combinational). On grant, wave_index=rd1_index and rd1_valid=1 next cycle.
  - With no grant, wave_index holds its previous value.
  - rd_data<=wave_height_in every cycle. The rdN_valid flags are registered versions of the grants, so exactly one or zero is high.
  - During WAIT, rd0 may read partially-updated data; this is accepted display behaviour.
- Reset mid-operation (any state) returns to WAIT with all reset values, including clearing timeout_err.

Test Plan:
- Reset, then wave_ready after 1030 cycles -> done pulse, cur_freq_id=0, state IDLE, timeout_err=0.
- In IDLE, req 7 held valid one cycle, MIN_HOLD=16 -> new_f pulses 17 cycles after acceptance with freq_id=7. wave_ready 600 cycles later -> cur_freq_id=7, done=1 for one cycle.
- Req 7, then req 9 after 10 cycles, then req equal to cur (0) after 5 more -> no new_f ever, state IDLE, cur_freq_id=0.
- Req 30 -> clamped, new_f with freq_id=24. Request during WAIT -> req_ready=0, not accepted.
- Enter WAIT, withhold wave_ready 2100 cycles -> timeout_err=1 (sticky), IDLE, cur_freq_id unchanged. Reset -> timeout_err=0.
- rd0_req and rd1_req both high with indices 5 and 9 in IDLE -> wave_index=5, rd1_grant=0, rd0_valid next cycle with rd_data=height[5]. rd0 drops -> rd1_grant=1, rd1_valid next cycle. rd1 in WAIT -> rd1_grant=0.
